// File: rtl/ppu_pkg.sv
// Shared definitions for the pipeline control path.
// Holds the default widths, the NOP control encoding and the control-word
// field offsets that the control unit and the pipeline registers agree on.
package ppu_pkg;

    localparam int CTRL_W_DEF = 32;
    localparam int PC_W_DEF   = 32;
    localparam int STAGES_DEF = 3;

    // A NOP is the all-zero control word: no write-back, no memory access,
    // no branch, so an emptied stage can never cause a side effect.
    localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;

    // Control-word field offsets (bit positions within the control word).
    localparam int CF_REG_WRITE  = 0;
    localparam int CF_MEM_TO_REG = 1;
    localparam int CF_MEM_READ   = 2;
    localparam int CF_MEM_WRITE  = 3;
    localparam int CF_BRANCH     = 4;
    localparam int CF_ALU_SRC    = 5;
    localparam int CF_ALU_OP     = 6;
    localparam int CF_ALU_OP_W   = 2;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Bundle of the control-pipeline signals.
//   master: drives in_ctrl/in_pc/in_valid/bubble/freeze/flush,
//           observes stage_ctrl/stage_pc/stage_valid/valid_count/bubble_count.
//   slave : the pipeline itself (inverse directions).
interface ctrl_pipe_if
    import ppu_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int STAGES = STAGES_DEF
) ();

    logic [CTRL_W-1:0]        in_ctrl;
    logic [PC_W-1:0]          in_pc;
    logic                     in_valid;
    logic                     bubble;
    logic                     freeze;
    logic [STAGES-1:0]        flush;
    logic [STAGES*CTRL_W-1:0] stage_ctrl;
    logic [STAGES*PC_W-1:0]   stage_pc;
    logic [STAGES-1:0]        stage_valid;
    logic [3:0]               valid_count;
    logic [15:0]              bubble_count;

    modport master (
        output in_ctrl, in_pc, in_valid, bubble, freeze, flush,
        input  stage_ctrl, stage_pc, stage_valid, valid_count, bubble_count
    );

    modport slave (
        input  in_ctrl, in_pc, in_valid, bubble, freeze, flush,
        output stage_ctrl, stage_pc, stage_valid, valid_count, bubble_count
    );

endinterface

// File: rtl/ctrl_pipe_stage.sv
// One pipeline register stage for the control word, its PC tag and valid bit.
// Ports:
//   clk, Reset            clock, asynchronous active-high reset
//   flush, freeze         per-edge priority: flush -> empty, freeze -> hold
//   src_ctrl/pc/valid     word offered by the previous stage (or the decoder)
//   ctrl_q/pc_q/valid_q   registered stage content
module ctrl_pipe_stage
    import ppu_pkg::*;
#(
    parameter int              CTRL_W = CTRL_W_DEF,
    parameter int              PC_W   = PC_W_DEF,
    parameter logic [CTRL_W-1:0] KEEP = '1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              freeze,
    input  logic [CTRL_W-1:0] src_ctrl,
    input  logic [PC_W-1:0]   src_pc,
    input  logic              src_valid,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [PC_W-1:0]   pc_q,
    output logic              valid_q
);

    logic [CTRL_W-1:0] ctrl_d;
    logic [PC_W-1:0]   pc_d;
    logic              valid_d;

    always_comb begin
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush) begin
            ctrl_d  = '0;
            pc_d    = '0;
            valid_d = 1'b0;
        end else if (!freeze) begin
            // An invalid source always lands as a clean NOP, whatever its
            // bits were, so downstream never sees stale control.
            if (src_valid) begin
                ctrl_d  = src_ctrl & KEEP;
                pc_d    = src_pc;
                valid_d = 1'b1;
            end else begin
                ctrl_d  = '0;
                pc_d    = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            ctrl_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline (ID/EX, EX/MEM, MEM/WB style) with bubble insertion,
// global freeze and per-stage flush.
// Ports:
//   clk, Reset  clock, asynchronous active-high reset
//   bus         ctrl_pipe_if.slave: decoder inputs and per-stage outputs,
//               plus valid_count (occupied stages) and bubble_count
//               (saturating count of empty loads into stage 0).
module ctrl_pipe
    import ppu_pkg::*;
#(
    parameter int                       CTRL_W    = CTRL_W_DEF,
    parameter int                       STAGES    = STAGES_DEF,
    parameter int                       PC_W      = PC_W_DEF,
    parameter logic [STAGES*CTRL_W-1:0] KEEP_MASK = '1
) (
    input logic        clk,
    input logic        Reset,
    ctrl_pipe_if.slave bus
);

    logic [CTRL_W-1:0] st_ctrl  [STAGES];
    logic [PC_W-1:0]   st_pc    [STAGES];
    logic              st_valid [STAGES];

    logic [15:0] bubble_count_q;
    logic [15:0] bubble_count_d;
    logic        load_empty;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [CTRL_W-1:0] src_ctrl;
        logic [PC_W-1:0]   src_pc;
        logic              src_valid;

        if (i == 0) begin : g_head
            // Control mux: a bubble replaces the decoded word with a NOP.
            assign src_ctrl  = bus.in_ctrl;
            assign src_pc    = bus.in_pc;
            assign src_valid = bus.in_valid & ~bus.bubble;
        end else begin : g_body
            assign src_ctrl  = st_ctrl[i-1];
            assign src_pc    = st_pc[i-1];
            assign src_valid = st_valid[i-1];
        end

        ctrl_pipe_stage #(
            .CTRL_W (CTRL_W),
            .PC_W   (PC_W),
            .KEEP   (KEEP_MASK[i*CTRL_W +: CTRL_W])
        ) u_stage (
            .clk       (clk),
            .Reset     (Reset),
            .flush     (bus.flush[i]),
            .freeze    (bus.freeze),
            .src_ctrl  (src_ctrl),
            .src_pc    (src_pc),
            .src_valid (src_valid),
            .ctrl_q    (st_ctrl[i]),
            .pc_q      (st_pc[i]),
            .valid_q   (st_valid[i])
        );
    end

    // Stage 0 takes an empty word only when it actually loads (not held,
    // not flushed) and the decoder offers nothing usable.
    assign load_empty = !bus.freeze && !bus.flush[0] && !(bus.in_valid && !bus.bubble);

    always_comb begin
        bubble_count_d = bubble_count_q;
        if (load_empty && bubble_count_q != 16'hFFFF) begin
            bubble_count_d = bubble_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            bubble_count_q <= '0;
        end else begin
            bubble_count_q <= bubble_count_d;
        end
    end

    always_comb begin
        bus.stage_ctrl   = '0;
        bus.stage_pc     = '0;
        bus.stage_valid  = '0;
        bus.valid_count  = '0;
        bus.bubble_count = bubble_count_q;
        for (int i = 0; i < STAGES; i++) begin
            bus.stage_ctrl[i*CTRL_W +: CTRL_W] = st_ctrl[i];
            bus.stage_pc[i*PC_W +: PC_W]       = st_pc[i];
            bus.stage_valid[i]                 = st_valid[i];
            bus.valid_count                    = bus.valid_count + 4'(st_valid[i]);
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

    localparam int CW = 8;
    localparam int PW = 8;
    localparam int NS = 3;

    logic clk;
    logic Reset;
    int   tests;
    int   fails;

    ctrl_pipe_if #(.CTRL_W(CW), .PC_W(PW), .STAGES(NS)) bus ();

    ctrl_pipe #(
        .CTRL_W    (CW),
        .STAGES    (NS),
        .PC_W      (PW),
        .KEEP_MASK ({8'h0F, 8'h3F, 8'hFF})
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stage contents as plain arrays, bubble count as int.
    logic [7:0] keep    [NS] = '{8'hFF, 8'h3F, 8'h0F};
    logic [7:0] m_ctrl  [NS];
    logic [7:0] m_pc    [NS];
    logic       m_valid [NS];
    int         m_bub;

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_ctrl[i] = '0; m_pc[i] = '0; m_valid[i] = 1'b0;
        end
        m_bub = 0;
    endtask

    task automatic model_edge();
        logic [7:0] nc [NS];
        logic [7:0] np [NS];
        logic       nv [NS];
        for (int i = 0; i < NS; i++) begin
            nc[i] = m_ctrl[i]; np[i] = m_pc[i]; nv[i] = m_valid[i];
            if (bus.flush[i]) begin
                nc[i] = 0; np[i] = 0; nv[i] = 0;
            end else if (!bus.freeze) begin
                if (i == 0) begin
                    if (bus.in_valid && !bus.bubble) begin
                        nc[i] = bus.in_ctrl & keep[0]; np[i] = bus.in_pc; nv[i] = 1;
                    end else begin
                        nc[i] = 0; np[i] = 0; nv[i] = 0;
                        if (m_bub < 65535) m_bub = m_bub + 1;
                    end
                end else if (m_valid[i-1]) begin
                    nc[i] = m_ctrl[i-1] & keep[i]; np[i] = m_pc[i-1]; nv[i] = 1;
                end else begin
                    nc[i] = 0; np[i] = 0; nv[i] = 0;
                end
            end
        end
        for (int i = 0; i < NS; i++) begin
            m_ctrl[i] = nc[i]; m_pc[i] = np[i]; m_valid[i] = nv[i];
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        int vc;
        vc = 0;
        for (int i = 0; i < NS; i++) vc += int'(m_valid[i]);
        chk({tag, ".ctrl"},  64'(bus.stage_ctrl),  64'({m_ctrl[2], m_ctrl[1], m_ctrl[0]}));
        chk({tag, ".pc"},    64'(bus.stage_pc),    64'({m_pc[2], m_pc[1], m_pc[0]}));
        chk({tag, ".valid"}, 64'(bus.stage_valid), 64'({m_valid[2], m_valid[1], m_valid[0]}));
        chk({tag, ".vcnt"},  64'(bus.valid_count), 64'(vc));
        chk({tag, ".bcnt"},  64'(bus.bubble_count), 64'(m_bub));
    endtask

    // One clock edge: inputs are stable across the edge; sample 1 time unit later.
    task automatic step(input string tag, input bit check);
        @(posedge clk);
        model_edge();
        #1;
        if (check) chk_all(tag);
    endtask

    task automatic drive(input logic [7:0] c, input logic [7:0] p, input logic v,
                         input logic b, input logic fz, input logic [2:0] fl);
        bus.in_ctrl = c; bus.in_pc = p; bus.in_valid = v;
        bus.bubble = b; bus.freeze = fz; bus.flush = fl;
    endtask

    task automatic fill_pipe();
        for (int k = 0; k < NS; k++) begin
            drive(8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0, 3'b000);
            step("fill", 1'b1);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        Reset = 1'b1;
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
        model_reset();
        #1;
        chk_all("reset");
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;

        // Single word travels through the masks.
        drive(8'hFF, 8'h10, 1'b1, 1'b0, 1'b0, 3'b000);
        step("w1", 1'b1);
        chk("w1.s0", 64'(bus.stage_ctrl[7:0]), 64'h FF);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
        step("w2", 1'b1);
        chk("w2.s1", 64'(bus.stage_ctrl[15:8]), 64'h3F);
        chk("w2.vc", 64'(bus.valid_count), 64'd1);
        step("w3", 1'b1);
        chk("w3.s2", 64'(bus.stage_ctrl[23:16]), 64'h0F);
        chk("w3.pc", 64'(bus.stage_pc[23:16]), 64'h10);

        // Bubble overrides a valid instruction.
        drive(8'hAA, 8'h20, 1'b1, 1'b1, 1'b0, 3'b000);
        step("bub", 1'b1);
        chk("bub.s0", 64'(bus.stage_ctrl[7:0]), 64'h00);
        chk("bub.v0", 64'(bus.stage_valid[0]), 64'd0);

        // Freeze a full pipe: nothing moves, count unchanged.
        fill_pipe();
        chk("full.v", 64'(bus.stage_valid), 64'b111);
        for (int k = 0; k < 3; k++) begin
            drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, 3'b000);
            step("frz", 1'b1);
        end
        drive(8'h5A, 8'h33, 1'b1, 1'b0, 1'b0, 3'b000);
        step("rel", 1'b1);
        chk("rel.s0", 64'(bus.stage_ctrl[7:0]), 64'h5A);

        // Freeze with flush of the middle stage.
        fill_pipe();
        drive(8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b1, 3'b010);
        step("frzfl", 1'b1);
        chk("frzfl.vc", 64'(bus.valid_count), 64'd2);

        // Randomized traffic with occasional freeze and flush.
        for (int k = 0; k < 400; k++) begin
            drive(8'($urandom), 8'($urandom), 1'($urandom_range(3) != 0),
                  1'($urandom_range(4) == 0), 1'($urandom_range(7) == 0),
                  {1'($urandom_range(9) == 0), 1'($urandom_range(9) == 0),
                   1'($urandom_range(9) == 0)});
            step("rnd", 1'b1);
        end

        // Asynchronous reset in the middle of a cycle with a full pipe.
        fill_pipe();
        @(posedge clk);
        model_edge();
        #3;
        Reset = 1'b1;
        model_reset();
        #1;
        chk_all("areset");
        @(negedge clk);
        Reset = 1'b0;
        drive(8'hC3, 8'h44, 1'b1, 1'b0, 1'b0, 3'b000);
        step("post", 1'b1);

        // Saturation of the bubble counter.
        drive(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'b000);
        for (int k = 0; k < 65540; k++) begin
            step("sat", 1'b0);
        end
        chk_all("sat");
        chk("sat.max", 64'(bus.bubble_count), 64'h FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
